// File: rtl/mem_ctrl_fsm.sv
// mem_ctrl_fsm: clocked data-port controller between the MEM stage and the
// board buses (base/ext SRAM, UART, LED and 7-seg registers).
// One request at a time: IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE.
// Ports: clk, rst_n (async, active low); req/we/addr/wdata/bytemode in;
//   ready (1-cycle pulse), rdata (aligned/extended), busy out;
//   base_ram_* / ext_ram_* SRAM buses, uart_rdn/uart_wrn strobes,
//   uart_dataready/uart_tbre/uart_tsre status, debug_leds, debug_dpys.
// Optional macro UART_TX_WAIT_EN: UART data writes hold in SETUP until
//   uart_tbre and uart_tsre are both high.
module mem_ctrl_fsm #(
    parameter int unsigned WAIT_CYCLES    = 2,
    parameter logic [31:0] UART_DATA_ADDR = 32'hBFD003F8,
    parameter logic [31:0] UART_STAT_ADDR = 32'hBFD003FC,
    parameter logic [31:0] LED_ADDR       = 32'hBFD00400,
    parameter logic [31:0] DPY_ADDR       = 32'hBFD00408
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  bytemode,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        busy,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    inout  wire  [31:0] ext_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_dataready,
    input  logic        uart_tbre,
    input  logic        uart_tsre,
    output logic [15:0] debug_leds,
    output logic [7:0]  debug_dpys
);

    localparam logic [3:0] ACC_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        T_UDATA,
        T_USTAT,
        T_LED,
        T_DPY,
        T_BASE,
        T_EXT
    } tgt_t;

    state_t      state_q;
    tgt_t        tgt_q, tgt_d;
    logic        we_q;
    logic [4:0]  bm_q;
    logic [15:0] wd_q;
    logic [3:0]  cnt_q;
    logic        ready_q, busy_q;
    logic [31:0] rdata_q, rd_d;
    logic [19:0] ram_addr_q;
    logic [3:0]  base_be_n_q, ext_be_n_q;
    logic        base_ce_n_q, base_oe_n_q, base_we_n_q;
    logic        ext_ce_n_q, ext_oe_n_q, ext_we_n_q;
    logic        uart_rdn_q, uart_wrn_q;
    logic        base_drv_q, ext_drv_q;
    logic [31:0] bus_out_q, wlane_d, rd_raw;
    logic [15:0] leds_q;
    logic [7:0]  dpys_q;
    logic        long_acc;
    logic        tx_hold;

`ifdef UART_TX_WAIT_EN
    assign tx_hold = (tgt_q == T_UDATA) && we_q && !(uart_tbre && uart_tsre);
`else
    logic unused_tbre;
    assign unused_tbre = uart_tbre;
    assign tx_hold     = 1'b0;
`endif

    // SRAM and UART data use the wait-state counter; the rest take 1 cycle.
    assign long_acc = (tgt_q == T_UDATA) || (tgt_q == T_BASE) ||
                      (tgt_q == T_EXT);

    always_comb begin
        if (addr == UART_DATA_ADDR)      tgt_d = T_UDATA;
        else if (addr == UART_STAT_ADDR) tgt_d = T_USTAT;
        else if (addr == LED_ADDR)       tgt_d = T_LED;
        else if (addr == DPY_ADDR)       tgt_d = T_DPY;
        else if (addr[22])               tgt_d = T_EXT;
        else                             tgt_d = T_BASE;
    end

    always_comb begin
        case (bytemode[3:0])
            4'b0001: wlane_d = {24'h0, wdata[7:0]};
            4'b0010: wlane_d = {16'h0, wdata[7:0], 8'h0};
            4'b0100: wlane_d = {8'h0, wdata[7:0], 16'h0};
            4'b1000: wlane_d = {wdata[7:0], 24'h0};
            4'b0011: wlane_d = {16'h0, wdata[15:0]};
            4'b1100: wlane_d = {wdata[15:0], 16'h0};
            default: wlane_d = wdata;
        endcase
    end

    function automatic logic [31:0] align_rd(input logic [31:0] w,
                                             input logic [4:0]  bm);
        logic sx;
        sx = ~bm[4];
        case (bm[3:0])
            4'b0001: return {{24{sx & w[7]}},  w[7:0]};
            4'b0010: return {{24{sx & w[15]}}, w[15:8]};
            4'b0100: return {{24{sx & w[23]}}, w[23:16]};
            4'b1000: return {{24{sx & w[31]}}, w[31:24]};
            4'b0011: return {{16{sx & w[15]}}, w[15:0]};
            4'b1100: return {{16{sx & w[31]}}, w[31:16]};
            default: return w;
        endcase
    endfunction

    assign rd_raw = (tgt_q == T_EXT) ? ext_ram_data : base_ram_data;

    always_comb begin
        case (tgt_q)
            T_UDATA: rd_d = {24'h0, base_ram_data[7:0]};
            T_USTAT: rd_d = {30'h0, uart_dataready, uart_tsre};
            T_BASE,
            T_EXT:   rd_d = align_rd(rd_raw, bm_q);
            default: rd_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tgt_q       <= T_BASE;
            we_q        <= 1'b0;
            bm_q        <= '0;
            wd_q        <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            base_be_n_q <= 4'hF;
            base_ce_n_q <= 1'b1;
            base_oe_n_q <= 1'b1;
            base_we_n_q <= 1'b1;
            ext_be_n_q  <= 4'hF;
            ext_ce_n_q  <= 1'b1;
            ext_oe_n_q  <= 1'b1;
            ext_we_n_q  <= 1'b1;
            uart_rdn_q  <= 1'b1;
            uart_wrn_q  <= 1'b1;
            base_drv_q  <= 1'b0;
            ext_drv_q   <= 1'b0;
            bus_out_q   <= '0;
            leds_q      <= '0;
            dpys_q      <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_q    <= S_SETUP;
                        busy_q     <= 1'b1;
                        tgt_q      <= tgt_d;
                        we_q       <= we;
                        bm_q       <= bytemode;
                        wd_q       <= wdata[15:0];
                        ram_addr_q <= addr[21:2];
                        // UART data shares the base bus on its low byte.
                        bus_out_q  <= (tgt_d == T_UDATA) ?
                                      {24'h0, wdata[7:0]} : wlane_d;
                        base_drv_q <= we && ((tgt_d == T_BASE) ||
                                             (tgt_d == T_UDATA));
                        ext_drv_q  <= we && (tgt_d == T_EXT);
                        if (tgt_d == T_BASE) begin
                            base_ce_n_q <= 1'b0;
                            base_be_n_q <= ~bytemode[3:0];
                            base_oe_n_q <= we;
                        end
                        if (tgt_d == T_EXT) begin
                            ext_ce_n_q <= 1'b0;
                            ext_be_n_q <= ~bytemode[3:0];
                            ext_oe_n_q <= we;
                        end
                    end
                end
                S_SETUP: begin
                    if (!tx_hold) begin
                        state_q     <= S_ACCESS;
                        cnt_q       <= long_acc ? ACC_LAST : 4'd0;
                        base_we_n_q <= !(we_q && (tgt_q == T_BASE));
                        ext_we_n_q  <= !(we_q && (tgt_q == T_EXT));
                        uart_wrn_q  <= !(we_q && (tgt_q == T_UDATA));
                        uart_rdn_q  <= !(!we_q && (tgt_q == T_UDATA));
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_DONE;
                        ready_q     <= 1'b1;
                        base_be_n_q <= 4'hF;
                        base_ce_n_q <= 1'b1;
                        base_oe_n_q <= 1'b1;
                        base_we_n_q <= 1'b1;
                        ext_be_n_q  <= 4'hF;
                        ext_ce_n_q  <= 1'b1;
                        ext_oe_n_q  <= 1'b1;
                        ext_we_n_q  <= 1'b1;
                        uart_rdn_q  <= 1'b1;
                        uart_wrn_q  <= 1'b1;
                        if (!we_q)
                            rdata_q <= rd_d;
                        else if (tgt_q == T_LED)
                            leds_q <= wd_q;
                        else if (tgt_q == T_DPY)
                            dpys_q <= wd_q[7:0];
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    // Bus kept driven through DONE for write hold time.
                    state_q    <= S_IDLE;
                    ready_q    <= 1'b0;
                    busy_q     <= 1'b0;
                    base_drv_q <= 1'b0;
                    ext_drv_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign base_ram_data = base_drv_q ? bus_out_q : 32'bz;
    assign ext_ram_data  = ext_drv_q  ? bus_out_q : 32'bz;

    assign ready         = ready_q;
    assign rdata         = rdata_q;
    assign busy          = busy_q;
    assign base_ram_addr = ram_addr_q;
    assign base_ram_be_n = base_be_n_q;
    assign base_ram_ce_n = base_ce_n_q;
    assign base_ram_oe_n = base_oe_n_q;
    assign base_ram_we_n = base_we_n_q;
    assign ext_ram_addr  = ram_addr_q;
    assign ext_ram_be_n  = ext_be_n_q;
    assign ext_ram_ce_n  = ext_ce_n_q;
    assign ext_ram_oe_n  = ext_oe_n_q;
    assign ext_ram_we_n  = ext_we_n_q;
    assign uart_rdn      = uart_rdn_q;
    assign uart_wrn      = uart_wrn_q;
    assign debug_leds    = leds_q;
    assign debug_dpys    = dpys_q;

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// tb_mem_ctrl_fsm: scoreboard bench for mem_ctrl_fsm with SRAM/UART models.
// Expected rdata/latency queued at drive time, popped on ready.
module tb_mem_ctrl_fsm;

    localparam int W       = 2;
    localparam int RAM_LAT = 2 + W;
`ifdef UART_TX_WAIT_EN
    localparam int TXW = 5;
`else
    localparam int TXW = 0;
`endif

    localparam logic [31:0] A_UDATA = 32'hBFD003F8;
    localparam logic [31:0] A_USTAT = 32'hBFD003FC;
    localparam logic [31:0] A_LED   = 32'hBFD00400;
    localparam logic [31:0] A_DPY   = 32'hBFD00408;

    logic        clk, rst_n, req, we;
    logic [31:0] addr, wdata, rdata;
    logic [4:0]  bytemode;
    logic        ready, busy;
    wire  [31:0] base_ram_data, ext_ram_data;
    logic [19:0] base_ram_addr, ext_ram_addr;
    logic [3:0]  base_ram_be_n, ext_ram_be_n;
    logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
    logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
    logic        uart_rdn, uart_wrn;
    logic        uart_dataready, uart_tbre, uart_tsre;
    logic [15:0] debug_leds;
    logic [7:0]  debug_dpys;

    logic [31:0] base_mem [256];
    logic [31:0] ext_mem  [256];
    logic [7:0]  uart_rx;

    int          ext_ce_cnt, wrn_cnt;
    logic [3:0]  be_snap;
    logic [7:0]  lane_snap, wr_byte;
    logic [19:0] snap_addr;

    int nvec, nerr;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        int          lat;
        bit          isrd;
    } exp_t;
    exp_t sb[$];

    mem_ctrl_fsm #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .bytemode(bytemode), .ready(ready), .rdata(rdata),
        .busy(busy), .base_ram_data(base_ram_data),
        .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
        .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n),
        .base_ram_we_n(base_ram_we_n), .ext_ram_data(ext_ram_data),
        .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
        .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n),
        .ext_ram_we_n(ext_ram_we_n), .uart_rdn(uart_rdn),
        .uart_wrn(uart_wrn), .uart_dataready(uart_dataready),
        .uart_tbre(uart_tbre), .uart_tsre(uart_tsre),
        .debug_leds(debug_leds), .debug_dpys(debug_dpys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign base_ram_data =
        (!base_ram_ce_n && !base_ram_oe_n) ? base_mem[base_ram_addr[7:0]] :
        (!uart_rdn) ? {24'h0, uart_rx} : 32'bz;
    assign ext_ram_data =
        (!ext_ram_ce_n && !ext_ram_oe_n) ? ext_mem[ext_ram_addr[7:0]] : 32'bz;

    always @(negedge clk) begin
        if (!base_ram_ce_n && !base_ram_we_n) begin
            be_snap   <= base_ram_be_n;
            lane_snap <= base_ram_data[23:16];
            for (int i = 0; i < 4; i++)
                if (!base_ram_be_n[i])
                    base_mem[base_ram_addr[7:0]][i*8 +: 8] <=
                        base_ram_data[i*8 +: 8];
        end
        if (!ext_ram_ce_n && !ext_ram_we_n)
            for (int j = 0; j < 4; j++)
                if (!ext_ram_be_n[j])
                    ext_mem[ext_ram_addr[7:0]][j*8 +: 8] <=
                        ext_ram_data[j*8 +: 8];
        if (!ext_ram_ce_n) ext_ce_cnt <= ext_ce_cnt + 1;
        if (!uart_wrn) begin
            wrn_cnt <= wrn_cnt + 1;
            wr_byte <= base_ram_data[7:0];
        end
    end

    initial begin
        ext_ce_cnt = 0;
        wrn_cnt    = 0;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] bm, input logic [31:0] exp_rd,
                        input int exp_lat, input int tbre_low,
                        input bit poke);
        int   n;
        exp_t e;
        sb.push_back('{tag, exp_rd, exp_lat, !w});
        @(negedge clk);
        we = w; addr = a; wdata = d; bytemode = bm; req = 1'b1;
        if (tbre_low > 0) uart_tbre = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                req = 1'b0;
                snap_addr = base_ram_addr;
                check({tag, "_busy"}, {31'h0, busy}, 32'd1);
            end
            if (tbre_low > 0) uart_tbre = (n > tbre_low);
            if (poke && n == 2) begin
                req = 1'b1; addr = A_LED; we = 1'b1; wdata = 32'hDEAD;
            end
            if (poke && n == 3) req = 1'b0;
        end while (!ready && n < 40);
        e = sb.pop_front();
        if (!ready) begin
            check({e.tag, "_timeout"}, {31'h0, ready}, 32'd1);
        end else begin
            check({e.tag, "_lat"}, 32'(n), 32'(e.lat));
            if (e.isrd) check({e.tag, "_rdata"}, rdata, e.rd);
        end
    endtask

    initial begin
        int e0, w0, r, first, second, n;
        nvec = 0; nerr = 0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        bytemode = '0; uart_dataready = 1'b0; uart_tbre = 1'b1;
        uart_tsre = 1'b1; uart_rx = 8'h9C;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, ready}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_strobes",
              {16'h0, base_ram_be_n, base_ram_ce_n, base_ram_oe_n,
               base_ram_we_n, ext_ram_be_n, ext_ram_ce_n, ext_ram_oe_n,
               ext_ram_we_n, uart_rdn, uart_wrn}, 32'h0000FFFF);
        check("rst_dbg", {8'h0, debug_leds, debug_dpys}, 32'd0);
        rst_n = 1'b1;

        e0 = ext_ce_cnt;
        xfer("base_wr", 1, 32'h80000010, 32'h12345678, 5'b01111, 0,
             RAM_LAT, 0, 0);
        check("base_wr_addr", {12'h0, snap_addr}, 32'h4);
        xfer("base_rd", 0, 32'h80000010, 0, 5'b01111, 32'h12345678,
             RAM_LAT, 0, 0);
        check("base_rd_addr", {12'h0, snap_addr}, 32'h4);
        check("base_mem4", base_mem[4], 32'h12345678);
        check("ext_ce_idle", 32'(ext_ce_cnt - e0), 32'd0);

        xfer("ext_wr", 1, 32'h80400020, 32'h80FF7F01, 5'b01111, 0,
             RAM_LAT, 0, 0);
        xfer("rd_b3s", 0, 32'h80400020, 0, 5'b01000, 32'hFFFFFF80,
             RAM_LAT, 0, 0);
        xfer("rd_b3z", 0, 32'h80400020, 0, 5'b11000, 32'h00000080,
             RAM_LAT, 0, 0);
        xfer("rd_h0s", 0, 32'h80400020, 0, 5'b00011, 32'h00007F01,
             RAM_LAT, 0, 0);
        xfer("rd_h1s", 0, 32'h80400020, 0, 5'b01100, 32'hFFFF80FF,
             RAM_LAT, 0, 0);

        xfer("pre_wr", 1, 32'h80000020, 32'h11223344, 5'b01111, 0,
             RAM_LAT, 0, 0);
        xfer("byte_st", 1, 32'h80000020, 32'h000000AB, 5'b00100, 0,
             RAM_LAT, 0, 0);
        check("byte_be_n", {28'h0, be_snap}, 32'hB);
        check("byte_lane", {24'h0, lane_snap}, 32'hAB);
        check("byte_mem", base_mem[8], 32'h11AB3344);
        xfer("half_st", 1, 32'h80000020, 32'h0000CAFE, 5'b01100, 0,
             RAM_LAT, 0, 0);
        xfer("half_rd", 0, 32'h80000020, 0, 5'b01111, 32'hCAFE3344,
             RAM_LAT, 0, 0);
        xfer("rd_b1s", 0, 32'h80000020, 0, 5'b00010, 32'h00000033,
             RAM_LAT, 0, 0);

        xfer("led_wr", 1, A_LED, 32'h0000BEEF, 5'b01111, 0, 3, 0, 0);
        check("led_val", {16'h0, debug_leds}, 32'hBEEF);
        xfer("dpy_wr", 1, A_DPY, 32'h123456A5, 5'b01111, 0, 3, 0, 0);
        check("dpy_val", {24'h0, debug_dpys}, 32'hA5);
        xfer("led_rd", 0, A_LED, 0, 5'b01111, 32'h0, 3, 0, 0);

        uart_dataready = 1'b1; uart_tsre = 1'b0;
        xfer("ustat_rd", 0, A_USTAT, 0, 5'b01111, 32'h2, 3, 0, 0);
        uart_dataready = 1'b0; uart_tsre = 1'b1;
        xfer("udata_rd", 0, A_UDATA, 0, 5'b01111, 32'h9C, RAM_LAT, 0, 0);

        w0 = wrn_cnt;
        xfer("udata_wr", 1, A_UDATA, 32'h00000141, 5'b01111, 0,
             RAM_LAT + TXW, 5, 1);
        check("uart_wrn_cycles", 32'(wrn_cnt - w0), 32'(W));
        check("uart_wr_byte", {24'h0, wr_byte}, 32'h41);
        r = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            r += int'(ready);
            if (k == 0) check("poke_busy", {31'h0, busy}, 32'd0);
        end
        check("poke_drop", 32'(r), 32'd0);
        check("poke_leds", {16'h0, debug_leds}, 32'hBEEF);

        @(negedge clk);
        we = 1'b1; addr = A_LED; wdata = 32'h1111; bytemode = 5'b01111;
        req = 1'b1;
        first = -1; second = -1; n = 0;
        while (second < 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (ready) begin
                if (first < 0) first = n;
                else begin second = n; req = 1'b0; end
            end
        end
        req = 1'b0;
        check("b2b_first", 32'(first), 32'd3);
        check("b2b_gap", 32'(second - first), 32'd4);
        repeat (2) @(negedge clk);
        check("rst_pre_leds", {16'h0, debug_leds}, 32'h1111);

        @(negedge clk);
        we = 1'b1; addr = 32'h80000030; wdata = 32'h5A5A5A5A;
        bytemode = 5'b01111; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("mid_we_low", {31'h0, base_ram_we_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_strobes",
              {24'h0, base_ram_ce_n, base_ram_we_n, base_ram_oe_n,
               ext_ram_ce_n, ext_ram_we_n, uart_rdn, uart_wrn, 1'b1},
              32'hFF);
        check("mid_ready_busy", {30'h0, ready, busy}, 32'd0);
        check("mid_leds", {16'h0, debug_leds}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r = 0;
        repeat (6) begin
            @(negedge clk);
            r += int'(ready);
        end
        check("mid_no_ready", 32'(r), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
